// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencing controller.
package fetch_ctrl_pkg;

  // Fetch PC mux select codes
  localparam logic [1:0] PCSEL_RESET = 2'b00;
  localparam logic [1:0] PCSEL_IRQ   = 2'b01;
  localparam logic [1:0] PCSEL_SEQ   = 2'b10;
  localparam logic [1:0] PCSEL_REDIR = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ISR  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_ctrl_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: arbitrates boot, interrupt entry, interrupt
// return and branch redirects, and parks redirects that arrive while fetch
// is frozen so they are applied on the first unfrozen cycle.
//
// state | meaning
// BOOT  | first cycle after reset, fetch from reset vector
// RUN   | normal fetch, interrupts may be taken
// ISR   | inside interrupt handler, irq masked, eret honoured
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pipe_stall_i,
  input  logic             imem_ready_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic [WIDTH-1:0] pc_plus_4_i,
  input  logic             irq_i,
  input  logic             eret_i,
  output logic [1:0]       pc_sel_o,
  output logic [WIDTH-1:0] redirect_pc_o,
  output logic             fetch_stall_o,
  output logic             flush_o,
  output logic             irq_ack_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             in_isr_o
);

  state_e           state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic [WIDTH-1:0] br_tgt_q, br_tgt_d;
  logic             eret_pend_q, eret_pend_d;
  logic [WIDTH-1:0] epc_q, epc_d;

  logic irq_s;
  logic hold;
  logic active;
  logic take_hold;
  logic take_eret;
  logic take_irq;
  logic take_redir;

  sync_2ff u_irq_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .d_i   (irq_i),
    .q_o   (irq_s)
  );

  // Priority decode shared by next-state and output logic; BOOT overrides all.
  assign hold       = pipe_stall_i | ~imem_ready_i;
  assign active     = (state_q != ST_BOOT);
  assign take_hold  = active & hold;
  assign take_eret  = (state_q == ST_ISR) & ~hold & (eret_i | eret_pend_q);
  assign take_irq   = (state_q == ST_RUN) & ~hold & irq_s;
  assign take_redir = active & ~hold & ~take_eret & ~take_irq
                    & (branch_taken_i | br_pend_q);

  // State and pending-request registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_BOOT;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= '0;
      eret_pend_q <= 1'b0;
      epc_q       <= '0;
    end else begin
      state_q     <= state_d;
      br_pend_q   <= br_pend_d;
      br_tgt_q    <= br_tgt_d;
      eret_pend_q <= eret_pend_d;
      epc_q       <= epc_d;
    end
  end

  // Next state and pending-request updates
  always_comb begin
    state_d     = state_q;
    br_pend_d   = br_pend_q;
    br_tgt_d    = br_tgt_q;
    eret_pend_d = eret_pend_q;
    epc_d       = epc_q;
    if (!active) begin
      state_d = ST_RUN;
    end else if (take_hold) begin
      // Newest redirect wins over any older parked one
      if (branch_taken_i) begin
        br_pend_d = 1'b1;
        br_tgt_d  = branch_target_i;
      end
      if ((state_q == ST_ISR) && eret_i) begin
        eret_pend_d = 1'b1;
      end
    end else if (take_eret) begin
      // A branch arriving with the return belongs to the handler and is dropped
      eret_pend_d = 1'b0;
      br_pend_d   = 1'b0;
      state_d     = ST_RUN;
    end else if (take_irq) begin
      // Resume where control flow was about to go, including any redirect
      if (branch_taken_i) begin
        epc_d = branch_target_i;
      end else if (br_pend_q) begin
        epc_d = br_tgt_q;
      end else begin
        epc_d = pc_plus_4_i;
      end
      br_pend_d = 1'b0;
      state_d   = ST_ISR;
    end else if (take_redir) begin
      br_pend_d = 1'b0;
    end
  end

  // Fetch control outputs
  always_comb begin
    pc_sel_o      = PCSEL_SEQ;
    fetch_stall_o = 1'b0;
    flush_o       = 1'b0;
    irq_ack_o     = 1'b0;
    redirect_pc_o = br_tgt_q;
    if (!active) begin
      pc_sel_o = PCSEL_RESET;
    end else if (take_hold) begin
      fetch_stall_o = 1'b1;
    end else if (take_eret) begin
      pc_sel_o      = PCSEL_REDIR;
      redirect_pc_o = epc_q;
      flush_o       = 1'b1;
    end else if (take_irq) begin
      pc_sel_o  = PCSEL_IRQ;
      flush_o   = 1'b1;
      irq_ack_o = 1'b1;
    end else if (take_redir) begin
      pc_sel_o      = PCSEL_REDIR;
      redirect_pc_o = branch_taken_i ? branch_target_i : br_tgt_q;
      flush_o       = 1'b1;
    end
  end

  assign epc_o    = epc_q;
  assign in_isr_o = (state_q == ST_ISR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the sequencing rules.
module tb_fetch_ctrl;

  localparam int MODE_BOOT = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_ISR  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_stall, imem_ready, branch_taken, irq, eret;
  logic [31:0] branch_target, pc_plus_4;
  logic [1:0]  pc_sel;
  logic [31:0] redirect_pc, epc;
  logic        fetch_stall, flush, irq_ack, in_isr;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int          m_mode;
  bit          m_bp, m_ep, m_s1, m_s2;
  logic [31:0] m_btgt, m_epc;

  // last observed outputs, for directed spot checks
  logic [1:0]  o_pc_sel;
  logic [31:0] o_redir, o_epc;
  logic        o_stall, o_flush, o_ack, o_isr;

  fetch_ctrl #(.WIDTH(32)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .pipe_stall_i    (pipe_stall),
    .imem_ready_i    (imem_ready),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .pc_plus_4_i     (pc_plus_4),
    .irq_i           (irq),
    .eret_i          (eret),
    .pc_sel_o        (pc_sel),
    .redirect_pc_o   (redirect_pc),
    .fetch_stall_o   (fetch_stall),
    .flush_o         (flush),
    .irq_ack_o       (irq_ack),
    .epc_o           (epc),
    .in_isr_o        (in_isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_BOOT;
    m_bp = 0; m_ep = 0; m_s1 = 0; m_s2 = 0;
    m_btgt = '0; m_epc = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance model at the edge.
  task automatic step(input bit ps, input bit ir, input bit bt, input logic [31:0] tgt,
                      input logic [31:0] pc4, input bit iq, input bit er);
    logic [1:0]  e_sel;
    logic [31:0] e_redir;
    bit          e_stall, e_flush, e_ack, held;
    int          act;
    pipe_stall = ps; imem_ready = ir; branch_taken = bt; branch_target = tgt;
    pc_plus_4 = pc4; irq = iq; eret = er;
    @(negedge clk);
    held = ps || !ir;
    e_sel = 2'b10; e_stall = 0; e_flush = 0; e_ack = 0; e_redir = m_btgt;
    if (m_mode == MODE_BOOT) begin
      e_sel = 2'b00; act = 0;
    end else if (held) begin
      e_stall = 1; act = 1;
    end else if (m_mode == MODE_ISR && (er || m_ep)) begin
      e_sel = 2'b11; e_redir = m_epc; e_flush = 1; act = 2;
    end else if (m_mode == MODE_RUN && m_s2) begin
      e_sel = 2'b01; e_flush = 1; e_ack = 1; act = 3;
    end else if (bt || m_bp) begin
      e_sel = 2'b11; e_redir = bt ? tgt : m_btgt; e_flush = 1; act = 4;
    end else begin
      act = 5;
    end
    o_pc_sel = pc_sel; o_redir = redirect_pc; o_epc = epc;
    o_stall = fetch_stall; o_flush = flush; o_ack = irq_ack; o_isr = in_isr;
    chk("pc_sel", {30'd0, pc_sel}, {30'd0, e_sel});
    chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, e_stall});
    chk("flush", {31'd0, flush}, {31'd0, e_flush});
    chk("irq_ack", {31'd0, irq_ack}, {31'd0, e_ack});
    chk("redirect_pc", redirect_pc, e_redir);
    chk("epc", epc, m_epc);
    chk("in_isr", {31'd0, in_isr}, {31'd0, m_mode == MODE_ISR});
    @(posedge clk);
    case (act)
      0: m_mode = MODE_RUN;
      1: begin
        if (bt) begin m_bp = 1; m_btgt = tgt; end
        if (m_mode == MODE_ISR && er) m_ep = 1;
      end
      2: begin m_ep = 0; m_bp = 0; m_mode = MODE_RUN; end
      3: begin
        m_epc = bt ? tgt : (m_bp ? m_btgt : pc4);
        m_bp = 0; m_mode = MODE_ISR;
      end
      4: m_bp = 0;
      default: ;
    endcase
    m_s2 = m_s1;
    m_s1 = iq;
    #1;
  endtask

  task automatic idle(input bit iq);
    step(0, 1, 0, 32'h0, 32'h4, iq, 0);
  endtask

  // Asynchronous reset assertion, checked immediately, released just after an edge.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_ack", {31'd0, irq_ack}, 32'd0);
    chk("rst_in_isr", {31'd0, in_isr}, 32'd0);
    chk("rst_redir", redirect_pc, 32'd0);
    chk("rst_epc", epc, 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit rps, rir, rbt, rer, riq;
    reset = 1'b1; pipe_stall = 0; imem_ready = 1; branch_taken = 0; irq = 0; eret = 0;
    branch_target = '0; pc_plus_4 = '0;
    model_reset();
    #2;
    do_reset(2);

    // reset release: one BOOT cycle, then sequential fetch
    idle(0);
    chk("boot_sel", {30'd0, o_pc_sel}, 32'd0);
    chk("boot_stall", {31'd0, o_stall}, 32'd0);
    idle(0);
    chk("run_sel", {30'd0, o_pc_sel}, 32'd2);

    // branch during memory wait
    step(0, 0, 1, 32'h40, 32'h8, 0, 0);
    chk("hold_stall0", {31'd0, o_stall}, 32'd1);
    step(0, 0, 0, 32'h0, 32'h8, 0, 0);
    step(0, 0, 0, 32'h0, 32'h8, 0, 0);
    chk("hold_stall2", {31'd0, o_stall}, 32'd1);
    idle(0);
    chk("pend_sel", {30'd0, o_pc_sel}, 32'd3);
    chk("pend_redir", o_redir, 32'h40);
    chk("pend_flush", {31'd0, o_flush}, 32'd1);
    idle(0);
    chk("pend_once", {31'd0, o_flush}, 32'd0);

    // interrupt from RUN with two-cycle sync latency
    step(0, 1, 0, 32'h0, 32'h10, 1, 0);
    chk("irq_lat0", {31'd0, o_ack}, 32'd0);
    step(0, 1, 0, 32'h0, 32'h10, 1, 0);
    chk("irq_lat1", {31'd0, o_ack}, 32'd0);
    step(0, 1, 0, 32'h0, 32'h10, 1, 0);
    chk("irq_ack", {31'd0, o_ack}, 32'd1);
    chk("irq_sel", {30'd0, o_pc_sel}, 32'd1);
    step(0, 1, 0, 32'h0, 32'h14, 1, 0);
    chk("isr_epc", o_epc, 32'h10);
    chk("isr_flag", {31'd0, o_isr}, 32'd1);
    repeat (3) begin
      idle(1);
      chk("isr_masked", {31'd0, o_ack}, 32'd0);
    end

    // return with a simultaneous branch; irq still high so it re-enters
    step(0, 1, 1, 32'h99, 32'h14, 1, 1);
    chk("eret_sel", {30'd0, o_pc_sel}, 32'd3);
    chk("eret_redir", o_redir, 32'h10);
    step(0, 1, 0, 32'h0, 32'h20, 1, 0);
    chk("eret_left", {31'd0, o_isr}, 32'd0);
    chk("irq_again", {31'd0, o_ack}, 32'd1);
    step(0, 1, 0, 32'h0, 32'h24, 0, 0);
    chk("epc_again", o_epc, 32'h20);

    // leave ISR with irq low, then interrupt coincident with a branch
    idle(0); idle(0);
    step(0, 1, 0, 32'h0, 32'h24, 0, 1);
    idle(0);
    chk("no_irq", {31'd0, o_ack}, 32'd0);
    idle(1); idle(1);
    step(0, 1, 1, 32'h80, 32'h30, 1, 0);
    chk("irqbr_ack", {31'd0, o_ack}, 32'd1);
    chk("irqbr_sel", {30'd0, o_pc_sel}, 32'd1);
    idle(0);
    chk("irqbr_epc", o_epc, 32'h80);
    idle(0);
    step(0, 1, 0, 32'h0, 32'h4, 0, 1);
    idle(0);

    // reset with a parked branch discards it
    step(0, 0, 1, 32'h55, 32'h4, 0, 0);
    do_reset(1);
    idle(0);
    chk("rst_boot", {30'd0, o_pc_sel}, 32'd0);
    idle(0);
    chk("rst_nopend", {31'd0, o_flush}, 32'd0);

    // random traffic
    riq = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 2));
      end
      rps = ($urandom_range(0, 99) < 20);
      rir = ($urandom_range(0, 99) < 80);
      rbt = ($urandom_range(0, 99) < 25);
      rer = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 6) riq = ~riq;
      step(rps, rir, rbt, $urandom, $urandom, riq, rer);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
